// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and carry-save datapath widths for the CSA accumulator.
package csa_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, DONE} state_t;
    localparam int CSA_LANES = 4;
    localparam int CSA_OP_W  = 4;
    localparam int CSA_SUM_W = 6;
endpackage

// File: rtl/csa_accum_ctrl_if.sv
// csa_accum_ctrl_if: job request, operand handshake and result bundle.
interface csa_accum_ctrl_if
    import csa_pkg::*;
#(
    parameter int ACC_W = 8
);
    logic                start;
    logic [4:0]          num_ops;
    logic                op_valid;
    logic [CSA_OP_W-1:0] op_data;
    logic                op_ready;
    logic                busy;
    logic [ACC_W-1:0]    result;
    logic                result_valid;
    logic                overflow;
    modport master (output start, num_ops, op_valid, op_data,
                    input  op_ready, busy, result, result_valid, overflow);
    modport slave  (input  start, num_ops, op_valid, op_data,
                    output op_ready, busy, result, result_valid, overflow);
endinterface

// File: rtl/carrysaveadder.sv
// carrysaveadder: four 4-bit operands reduced by two 3:2 layers, then one final carry-propagate add.
module carrysaveadder
    import csa_pkg::*;
(
    input  logic [CSA_OP_W-1:0]  a,
    input  logic [CSA_OP_W-1:0]  b,
    input  logic [CSA_OP_W-1:0]  c,
    input  logic [CSA_OP_W-1:0]  d,
    output logic [CSA_SUM_W-2:0] sum,
    output logic                 cout
);
    logic [3:0] s1, c1;
    logic [4:0] x, y, z, s2, c2;
    assign s1 = a ^ b ^ c;
    assign c1 = (a & b) | (a & c) | (b & c);
    assign x  = {1'b0, s1};
    assign y  = {c1, 1'b0};
    assign z  = {1'b0, d};
    assign s2 = x ^ y ^ z;
    assign c2 = (x & y) | (x & z) | (y & z);
    assign {cout, sum} = {1'b0, s2} + {c2, 1'b0};
endmodule

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: packs up to MAX_OPS operands four per group and accumulates each group
// through a single shared carry-save adder.
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int MAX_OPS = 16
)(
    input logic             clk,
    input logic             rst_n,
    csa_accum_ctrl_if.slave bus
);
    state_t                    state_q;
    logic [CSA_OP_W-1:0]       lane_q [CSA_LANES];
    logic [1:0]                idx_q;
    logic [4:0]                rem_q;
    logic [ACC_W-1:0]          acc_q, res_q;
    logic                      rv_q, ovf_q;
    logic [CSA_SUM_W-2:0]      csa_sum;
    logic                      csa_cout;
    logic [ACC_W:0]            acc_d;
    logic [4:0]                n_d;

    carrysaveadder u_csa (
        .a(lane_q[0]), .b(lane_q[1]), .c(lane_q[2]), .d(lane_q[3]),
        .sum(csa_sum), .cout(csa_cout)
    );

    assign n_d   = bus.num_ops > 5'(MAX_OPS) ? 5'(MAX_OPS) : bus.num_ops;
    assign acc_d = {1'b0, acc_q} + (ACC_W+1)'({csa_cout, csa_sum});

    // result and result_valid are loaded on the edge into DONE so both are visible together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '{default: '0};
            idx_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    rem_q   <= n_d;
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                    lane_q  <= '{default: '0};
                    idx_q   <= '0;
                    state_q <= n_d == '0 ? DONE : COLLECT;
                    if (n_d == '0) begin
                        res_q <= '0;
                        rv_q  <= 1'b1;
                    end
                end
                COLLECT: if (bus.op_valid) begin
                    lane_q[idx_q] <= bus.op_data;
                    idx_q         <= idx_q + 2'd1;
                    rem_q         <= rem_q - 5'd1;
                    state_q       <= (idx_q == 2'd3 || rem_q == 5'd1) ? ISSUE : COLLECT;
                end
                ISSUE: begin
                    acc_q   <= acc_d[ACC_W-1:0];
                    ovf_q   <= ovf_q | acc_d[ACC_W];
                    lane_q  <= '{default: '0};
                    idx_q   <= '0;
                    state_q <= rem_q == '0 ? DONE : COLLECT;
                    if (rem_q == '0) begin
                        res_q <= acc_d[ACC_W-1:0];
                        rv_q  <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign bus.op_ready     = state_q == COLLECT;
    assign bus.busy         = state_q != IDLE;
    assign bus.result       = res_q;
    assign bus.result_valid = rv_q;
    assign bus.overflow     = ovf_q;
endmodule
